// File: rtl/cnt_mod_param.sv
// rtl/cnt_mod_param.sv - modulo-N up/down counter with prescaler, clear/load, wrap/saturate, tc and sticky ovf; optional capture via CNT_CAPTURE_EN
module cnt_mod_param #(
    parameter int WIDTH    = 8,
    parameter int MODULO   = 256,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             sat,
    input  logic             ovf_clr,
`ifdef CNT_CAPTURE_EN
    input  logic             cap,
    output logic [WIDTH-1:0] cap_val,
`endif
    output logic [WIDTH-1:0] cnt,
    output logic             tick,
    output logic             tc,
    output logic             ovf
);

    // Prescaler register is at least one bit wide even when PRESCALE is 1.
    localparam int               PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PMAX = PW'(PRESCALE - 1);
    // Terminal value kept at WIDTH bits so MODULO == 2**WIDTH never overflows.
    localparam logic [WIDTH-1:0] CMAX = WIDTH'(MODULO - 1);

    if (WIDTH < 1) begin : g_bad_width
        $error("cnt_mod_param: WIDTH must be >= 1");
    end
    if (MODULO < 2 || longint'(MODULO) > (longint'(1) << WIDTH)) begin : g_bad_modulo
        $error("cnt_mod_param: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("cnt_mod_param: PRESCALE must be >= 1");
    end

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             step;

    // Step strobe: enabled clock at the end of the prescale period, masked by clear/load.
    always_comb begin
        step = en & ~clr & ~load & (presc_q == PMAX);
        tick = step & ~rst;
    end

    // Next-state: clear beats load beats step; ovf_clr is overridden by a boundary set.
    always_comb begin
        cnt_d   = cnt_q;
        presc_d = presc_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q & ~ovf_clr;
        if (clr) begin
            cnt_d   = '0;
            presc_d = '0;
        end else if (load) begin
            cnt_d   = (load_val > CMAX) ? CMAX : load_val;
            presc_d = '0;
        end else if (en) begin
            if (presc_q == PMAX) begin
                presc_d = '0;
                if (dir) begin
                    if (cnt_q != CMAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        tc_d  = 1'b1;
                        ovf_d = 1'b1;
                        if (!sat) cnt_d = '0;
                    end
                end else begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        tc_d  = 1'b1;
                        ovf_d = 1'b1;
                        if (!sat) cnt_d = CMAX;
                    end
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            presc_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef CNT_CAPTURE_EN
    logic [WIDTH-1:0] cap_val_q;

    // Snapshot of the pre-edge count; independent of en and of any step on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_val_q <= '0;
        end else if (cap) begin
            cap_val_q <= cnt_q;
        end
    end

    assign cap_val = cap_val_q;
`endif

    assign cnt = cnt_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_cnt_mod_param.sv
// tb/tb_cnt_mod_param.sv - scoreboard bench for cnt_mod_param (8/256/1 and 4/10/4 instances)
module tb_cnt_mod_param;

    logic       clk = 1'b0;
    logic       rst, en, clr, load, dir, sat, ovf_clr, cap;
    logic [7:0] lv;

    logic [7:0] cnt_a, cap_a;
    logic       tick_a, tc_a, ovf_a;
    logic [3:0] cnt_b, cap_b;
    logic       tick_b, tc_b, ovf_b;

    int total = 0;
    int bad   = 0;
    int tca   = 0;
    int tcb   = 0;
    int tkb   = 0;

    typedef struct {
        int cnt;
        int presc;
        int tc;
        int ovf;
        int capv;
    } st_t;

    typedef struct {
        st_t a;
        st_t b;
    } exp_t;

    st_t  ma, mb;
    exp_t sb_q[$];

    always #10 clk = ~clk;

    cnt_mod_param #(.WIDTH(8), .MODULO(256), .PRESCALE(1)) u_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(lv),
        .dir(dir), .sat(sat), .ovf_clr(ovf_clr),
`ifdef CNT_CAPTURE_EN
        .cap(cap), .cap_val(cap_a),
`endif
        .cnt(cnt_a), .tick(tick_a), .tc(tc_a), .ovf(ovf_a)
    );

    cnt_mod_param #(.WIDTH(4), .MODULO(10), .PRESCALE(4)) u_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(lv[3:0]),
        .dir(dir), .sat(sat), .ovf_clr(ovf_clr),
`ifdef CNT_CAPTURE_EN
        .cap(cap), .cap_val(cap_b),
`endif
        .cnt(cnt_b), .tick(tick_b), .tc(tc_b), .ovf(ovf_b)
    );

`ifndef CNT_CAPTURE_EN
    assign cap_a = '0;
    assign cap_b = '0;
`endif

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour of one channel for one clock edge.
    task automatic mdl(input st_t s, input int modulo, input int prescale, input int ldv,
                       output st_t n, output int tk);
        n    = s;
        tk   = 0;
        n.tc = 0;
        if (ovf_clr) n.ovf = 0;
`ifdef CNT_CAPTURE_EN
        if (cap) n.capv = s.cnt;
`endif
        if (clr) begin
            n.cnt   = 0;
            n.presc = 0;
        end else if (load) begin
            n.cnt   = (ldv >= modulo) ? modulo - 1 : ldv;
            n.presc = 0;
        end else if (en) begin
            if (s.presc == prescale - 1) begin
                tk      = 1;
                n.presc = 0;
                if (dir) begin
                    if (s.cnt < modulo - 1) n.cnt = s.cnt + 1;
                    else begin
                        n.tc  = 1;
                        n.ovf = 1;
                        if (!sat) n.cnt = 0;
                    end
                end else begin
                    if (s.cnt > 0) n.cnt = s.cnt - 1;
                    else begin
                        n.tc  = 1;
                        n.ovf = 1;
                        if (!sat) n.cnt = modulo - 1;
                    end
                end
            end else begin
                n.presc = s.presc + 1;
            end
        end
    endtask

    // One clock: inputs already driven after a falling edge; ends on the next falling edge.
    task automatic cyc();
        st_t  na, nb;
        int   tka, tkbb;
        exp_t e;
        #1;
        mdl(ma, 256, 1, int'(lv), na, tka);
        mdl(mb, 10, 4, int'(lv[3:0]), nb, tkbb);
        check("tick_a", int'(tick_a), tka);
        check("tick_b", int'(tick_b), tkbb);
        if (tick_b) tkb++;
        sb_q.push_back('{a: na, b: nb});
        ma = na;
        mb = nb;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("cnt_a", int'(cnt_a), e.a.cnt);
        check("tc_a",  int'(tc_a),  e.a.tc);
        check("ovf_a", int'(ovf_a), e.a.ovf);
        check("cnt_b", int'(cnt_b), e.b.cnt);
        check("tc_b",  int'(tc_b),  e.b.tc);
        check("ovf_b", int'(ovf_b), e.b.ovf);
`ifdef CNT_CAPTURE_EN
        check("cap_a", int'(cap_a), e.a.capv);
        check("cap_b", int'(cap_b), e.b.capv);
`endif
        if (tc_a) tca++;
        if (tc_b) tcb++;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; dir = 1'b0;
        sat = 1'b0; ovf_clr = 1'b0; cap = 1'b0; lv = 8'd0;
        ma = '{default: 0};
        mb = '{default: 0};

        // Reset state.
        #190;
        check("rst_cnt_a", int'(cnt_a), 0);
        check("rst_tc_a", int'(tc_a), 0);
        check("rst_ovf_a", int'(ovf_a), 0);
        check("rst_tick_a", int'(tick_a), 0);
        check("rst_cnt_b", int'(cnt_b), 0);
        #10;
        rst = 1'b0;

        // Free run over a full 8-bit wrap.
        en = 1'b1; dir = 1'b1; sat = 1'b0;
        tca = 0;
        repeat (257) cyc();
        check("t1_tc_pulses", tca, 1);
        check("t1_cnt_a", int'(cnt_a), 1);
        check("t1_ovf_a", int'(ovf_a), 1);
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        check("t1_ovf_clr", int'(ovf_a), 0);

        // MODULO=10 with prescale 4.
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        tkb = 0;
        repeat (40) cyc();
        check("t2_ticks", tkb, 10);
        check("t2_cnt_b", int'(cnt_b), 0);
        check("t2_tc_b", int'(tc_b), 1);

        // Saturate up from 7, then wrap down from 0.
        lv = 8'd7; load = 1'b1;
        cyc();
        load = 1'b0; sat = 1'b1; dir = 1'b1;
        tcb = 0;
        repeat (20) cyc();
        check("t3_sat_cnt", int'(cnt_b), 9);
        check("t3_sat_tcs", tcb, 3);
        clr = 1'b1;
        cyc();
        clr = 1'b0; dir = 1'b0; sat = 1'b0;
        repeat (4) cyc();
        check("t3_wrap_cnt", int'(cnt_b), 9);
        check("t3_wrap_tc", int'(tc_b), 1);

        // Clear over load, clamp on load, freeze with en low.
        clr = 1'b1; load = 1'b1; lv = 8'd3;
        cyc();
        check("t4_prio_b", int'(cnt_b), 0);
        check("t4_prio_a", int'(cnt_a), 0);
        clr = 1'b0; lv = 8'd15;
        cyc();
        check("t4_clamp_b", int'(cnt_b), 9);
        check("t4_load_a", int'(cnt_a), 15);
        load = 1'b0; en = 1'b0;
        tkb = 0;
        repeat (20) cyc();
        check("t4_hold_b", int'(cnt_b), 9);
        check("t4_noticks", tkb, 0);

        // Asynchronous reset mid-count.
        lv = 8'h50; load = 1'b1;
        cyc();
        load = 1'b0; en = 1'b1; dir = 1'b1;
        repeat (10) cyc();
        check("t5_pre_cnt", int'(cnt_a), 8'h5A);
        #4;
        rst = 1'b1;
        #1;
        check("t5_rst_cnt_a", int'(cnt_a), 0);
        check("t5_rst_ovf_a", int'(ovf_a), 0);
        check("t5_rst_ovf_b", int'(ovf_b), 0);
        check("t5_rst_cnt_b", int'(cnt_b), 0);
        ma = '{default: 0};
        mb = '{default: 0};
        #2;
        rst = 1'b0;
        cyc();
        check("t5_resume", int'(cnt_a), 1);

`ifdef CNT_CAPTURE_EN
        // Capture on the 0x11 -> 0x12 edge.
        lv = 8'h11; load = 1'b1;
        cyc();
        load = 1'b0; cap = 1'b1;
        cyc();
        cap = 1'b0;
        check("t6_cap", int'(cap_a), 8'h11);
        check("t6_cnt", int'(cnt_a), 8'h12);
        repeat (3) cyc();
        check("t6_cap_hold", int'(cap_a), 8'h11);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
